// File: rtl/gppcu_queue_pkg.sv
// Shared constants for the GPPCU command queue: host opcodes, CONTROL sub-commands
// and the layout of the status word returned on CONTROL reads.
package gppcu_queue_pkg;

  localparam logic [6:0] OP_PUSH_INSTR = 7'd0;
  localparam logic [6:0] OP_RD_LMEM    = 7'd1;
  localparam logic [6:0] OP_WR_LMEM    = 7'd2;
  localparam logic [6:0] OP_WR_GMEM    = 7'd3;
  localparam logic [6:0] OP_CONTROL    = 7'd4;

  localparam logic [7:0] CTL_RUN         = 8'd0;
  localparam logic [7:0] CTL_NUM_CYCLES  = 8'd1;
  localparam logic [7:0] CTL_SZ_PER_TASK = 8'd2;
  localparam logic [7:0] CTL_CLEAR       = 8'd3;

  localparam int ST_RUNNING  = 31;
  localparam int ST_DONE     = 30;
  localparam int ST_OFST_LSB = 24;
  localparam int ST_PEND_LSB = 16;
  localparam int ST_HEAD_LSB = 8;
  localparam int ST_NCYC_LSB = 4;
  localparam int ST_CIDX_LSB = 0;

  function automatic logic [31:0] pack_status(
    input logic       running,
    input logic       done,
    input logic [5:0] ofst,
    input logic [7:0] pend,
    input logic [7:0] head,
    input logic [3:0] ncyc,
    input logic [3:0] cidx
  );
    logic [31:0] s;
    s = '0;
    s[ST_RUNNING]         = running;
    s[ST_DONE]            = done;
    s[ST_OFST_LSB +: 6]   = ofst;
    s[ST_PEND_LSB +: 8]   = pend;
    s[ST_HEAD_LSB +: 8]   = head;
    s[ST_NCYC_LSB +: 4]   = ncyc;
    s[ST_CIDX_LSB +: 4]   = cidx;
    return s;
  endfunction

endpackage

// File: rtl/dpram_param.sv
// Simple dual-port RAM: port A synchronous write, port B asynchronous read.
module dpram_param #(
  parameter int DBW   = 32,
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [DBW-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [DBW-1:0] rdata
);

  logic [DBW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gppcu_cmd_queue.sv
// Host command front end for a GPPCU core: program load/replay, local-memory proxy and
// global constant memory. Optional macro GPPCU_QUEUE_OFST_OVERLAY_EN maps task_ofst onto gmem address 0.
module gppcu_cmd_queue
  import gppcu_queue_pkg::*;
#(
  parameter int QBW = 12,
  parameter int GBW = 10
) (
  input  logic        opclk,
  input  logic        inRST,
  input  logic        aclk,
  input  logic [6:0]  iWPARAM,
  input  logic [7:0]  iLPARAM,
  input  logic [15:0] iCOMMAND,
  input  logic [31:0] iDATA,
  output logic [31:0] oDATA,
  output logic        oDONE,
  output logic [31:0] oINSTR,
  output logic        oINSTR_VALID,
  input  logic        iINSTR_READY,
  output logic [7:0]  oLMEM_THREAD_SEL,
  output logic [15:0] oLMEM_ADDR,
  output logic [31:0] oLMEM_WDATA,
  output logic        oLMEM_RD,
  output logic        oLMEM_WR,
  input  logic [31:0] iLMEM_RDATA,
  input  logic [16:0] iGMEM_ADDR,
  output logic [31:0] oGMEM_RDATA
);

  // host (opclk) domain state
  logic [QBW-1:0] pmem_end;
  logic           running;
  logic [11:0]    num_cycles;
  logic [31:0]    sz_per_task;

  // core (aclk) domain state
  logic           run_q1;
  logic           run_s;
  logic [QBW-1:0] head;
  logic [31:0]    task_ofst;
  logic [11:0]    cycle_idx;
  logic           done;

  logic           pmem_we;
  logic           gmem_we;
  logic [31:0]    gmem_rdata;

  // The program never wraps: the last slot stays empty so head==pmem_end means "end of pass".
  assign pmem_we = (iWPARAM == OP_PUSH_INSTR) && !running && (pmem_end != {QBW{1'b1}});
  assign gmem_we = (iWPARAM == OP_WR_GMEM);

  always_ff @(posedge opclk or negedge inRST) begin
    if (!inRST) begin
      pmem_end    <= '0;
      running     <= 1'b0;
      num_cycles  <= '0;
      sz_per_task <= '0;
    end else begin
      if (pmem_we) pmem_end <= pmem_end + 1'b1;
      if (iWPARAM == OP_CONTROL) begin
        case (iLPARAM)
          CTL_RUN:         running     <= iCOMMAND[0];
          CTL_NUM_CYCLES:  num_cycles  <= iCOMMAND[11:0];
          CTL_SZ_PER_TASK: sz_per_task <= {16'h0000, iCOMMAND};
          CTL_CLEAR: begin
            pmem_end <= '0;
            running  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  dpram_param #(.DBW(32), .DEPTH(2**QBW)) u_pmem (
    .clk   (opclk),
    .we    (pmem_we),
    .waddr (pmem_end),
    .wdata (iDATA),
    .raddr (head),
    .rdata (oINSTR)
  );

  dpram_param #(.DBW(32), .DEPTH(2**GBW)) u_gmem (
    .clk   (opclk),
    .we    (gmem_we),
    .waddr (iCOMMAND[GBW-1:0]),
    .wdata (iDATA),
    .raddr (iGMEM_ADDR[GBW-1:0]),
    .rdata (gmem_rdata)
  );

  always_ff @(posedge aclk or negedge inRST) begin
    if (!inRST) begin
      run_q1 <= 1'b0;
      run_s  <= 1'b0;
    end else begin
      run_q1 <= running;
      run_s  <= run_q1;
    end
  end

  // pmem_end, num_cycles and sz_per_task are only changed by the host while stopped,
  // so the core domain reads them without synchronisation.
  always_ff @(posedge aclk or negedge inRST) begin
    if (!inRST) begin
      head      <= '0;
      task_ofst <= '0;
      cycle_idx <= '0;
      done      <= 1'b0;
    end else if (!run_s) begin
      head      <= '0;
      task_ofst <= '0;
      cycle_idx <= '0;
      done      <= 1'b0;
    end else if (cycle_idx == num_cycles) begin
      done <= 1'b1;
    end else if (head < pmem_end) begin
      head <= head + QBW'(iINSTR_READY);
    end else begin
      head      <= '0;
      task_ofst <= task_ofst + sz_per_task;
      cycle_idx <= cycle_idx + 1'b1;
    end
  end

  // Handshake: a word transfers on an aclk rising edge where oINSTR_VALID and iINSTR_READY
  // are both high; oINSTR holds while valid is high and ready is low. Valid is also gated
  // on the last pass having finished so no word is offered in the cycle before done rises.
  assign oINSTR_VALID = run_s && !done && (head != pmem_end) && (cycle_idx != num_cycles);
  assign oDONE        = done;

  assign oLMEM_THREAD_SEL = iLPARAM;
  assign oLMEM_ADDR       = iCOMMAND;
  assign oLMEM_WDATA      = iDATA;
  assign oLMEM_RD         = (iWPARAM == OP_RD_LMEM);
  assign oLMEM_WR         = (iWPARAM == OP_WR_LMEM);

  assign oDATA = (iWPARAM == OP_CONTROL)
               ? pack_status(running, done, task_ofst[5:0], pmem_end[7:0], head[7:0],
                             num_cycles[3:0], cycle_idx[3:0])
               : iLMEM_RDATA;

`ifdef GPPCU_QUEUE_OFST_OVERLAY_EN
  assign oGMEM_RDATA = (iGMEM_ADDR == 17'd0) ? task_ofst : gmem_rdata;
`else
  assign oGMEM_RDATA = gmem_rdata;
`endif

  logic unused_bits;
  assign unused_bits = ^{task_ofst[31:6], iGMEM_ADDR[16:GBW]};

endmodule

// File: tb/tb_gppcu_cmd_queue.sv
// Directed-plus-random bench for gppcu_cmd_queue: a program/pass model feeds an expected
// instruction queue that the core-side handshake monitor drains.
module tb_gppcu_cmd_queue;

  localparam logic [6:0] IDLE_OP = 7'h7F;

  logic        opclk, aclk, inRST;
  logic [6:0]  iWPARAM;
  logic [7:0]  iLPARAM;
  logic [15:0] iCOMMAND;
  logic [31:0] iDATA;
  logic [31:0] oDATA;
  logic        oDONE;
  logic [31:0] oINSTR;
  logic        oINSTR_VALID;
  logic        iINSTR_READY;
  logic [7:0]  oLMEM_THREAD_SEL;
  logic [15:0] oLMEM_ADDR;
  logic [31:0] oLMEM_WDATA;
  logic        oLMEM_RD, oLMEM_WR;
  logic [31:0] iLMEM_RDATA;
  logic [16:0] iGMEM_ADDR;
  logic [31:0] oGMEM_RDATA;

  gppcu_cmd_queue dut (
    .opclk(opclk), .inRST(inRST), .aclk(aclk),
    .iWPARAM(iWPARAM), .iLPARAM(iLPARAM), .iCOMMAND(iCOMMAND), .iDATA(iDATA),
    .oDATA(oDATA), .oDONE(oDONE),
    .oINSTR(oINSTR), .oINSTR_VALID(oINSTR_VALID), .iINSTR_READY(iINSTR_READY),
    .oLMEM_THREAD_SEL(oLMEM_THREAD_SEL), .oLMEM_ADDR(oLMEM_ADDR), .oLMEM_WDATA(oLMEM_WDATA),
    .oLMEM_RD(oLMEM_RD), .oLMEM_WR(oLMEM_WR), .iLMEM_RDATA(iLMEM_RDATA),
    .iGMEM_ADDR(iGMEM_ADDR), .oGMEM_RDATA(oGMEM_RDATA)
  );

  // clock / reset
  initial begin
    opclk = 1'b0;
    forever #5 opclk = ~opclk;
  end
  initial begin
    aclk = 1'b0;
    forever #7 aclk = ~aclk;
  end

  int errors = 0;
  int checks = 0;

  // reference model
  logic [31:0] exp_q[$];
  logic [31:0] m_pmem[$];
  bit          m_running;
  logic [31:0] m_nc;
  logic [31:0] m_sz;
  int          hs;
  int          stall_at;
  int          stall_left;
  bit          rdy_random;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit run, input bit dn, input logic [31:0] ofst,
                                             input int pend, input int hd, input logic [31:0] nc,
                                             input logic [31:0] cyc);
    return {run, dn, ofst[5:0], pend[7:0], hd[7:0], nc[3:0], cyc[3:0]};
  endfunction

  function automatic logic [31:0] m_ofst();
    return m_nc * m_sz;
  endfunction

  // driver tasks
  task automatic host(input logic [6:0] wp, input logic [7:0] lp, input logic [15:0] cmd,
                      input logic [31:0] d);
    @(negedge opclk);
    iWPARAM = wp; iLPARAM = lp; iCOMMAND = cmd; iDATA = d;
    @(negedge opclk);
    iWPARAM = IDLE_OP;
  endtask

  task automatic read_status(output logic [31:0] s);
    @(negedge opclk);
    iWPARAM = 7'd4; iLPARAM = 8'hFF;
    #1 s = oDATA;
    iWPARAM = IDLE_OP;
  endtask

  task automatic push_word(input logic [31:0] d);
    host(7'd0, 8'd0, 16'd0, d);
    if (!m_running && m_pmem.size() < 4095) m_pmem.push_back(d);
  endtask

  task automatic set_cycles(input int nc, input int sz);
    host(7'd4, 8'd1, 16'(nc), 32'd0);
    host(7'd4, 8'd2, 16'(sz), 32'd0);
    m_nc = 32'(nc);
    m_sz = 32'(sz);
  endtask

  task automatic start_run();
    exp_q.delete();
    for (int c = 0; c < int'(m_nc); c++)
      foreach (m_pmem[w]) exp_q.push_back(m_pmem[w]);
    hs = 0;
    host(7'd4, 8'd0, 16'd1, 32'd0);
    m_running = 1'b1;
  endtask

  task automatic stop_run();
    host(7'd4, 8'd0, 16'd0, 32'd0);
    m_running = 1'b0;
    repeat (5) @(negedge aclk);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (oDONE !== 1'b1 && n < 5000) begin
      @(posedge aclk);
      n++;
    end
    repeat (3) @(negedge aclk);
    check({tag, "_done"}, oDONE, 1'b1);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // core-side driver and scoreboard
  initial begin
    iINSTR_READY = 1'b0;
    forever begin
      @(negedge aclk);
      if (stall_left > 0) begin
        iINSTR_READY = 1'b0;
        stall_left--;
        #1;
        if (exp_q.size() > 0) begin
          check("stall_valid", oINSTR_VALID, 1'b1);
          check("stall_instr", oINSTR, exp_q[0]);
        end
      end else begin
        iINSTR_READY = rdy_random ? ($urandom_range(0, 3) != 0) : 1'b1;
        #1;
        if (oINSTR_VALID && iINSTR_READY) begin
          hs++;
          check("hs_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("instr_word", oINSTR, exp_q.pop_front());
          if (hs == stall_at) stall_left = 5;
        end
      end
    end
  end

  logic [31:0] st;
  logic [31:0] rd;

  initial begin
    inRST = 1'b0;
    iWPARAM = IDLE_OP; iLPARAM = '0; iCOMMAND = '0; iDATA = '0;
    iLMEM_RDATA = '0; iGMEM_ADDR = '0;
    m_running = 1'b0; m_nc = '0; m_sz = '0;
    hs = 0; stall_at = 0; stall_left = 0; rdy_random = 1'b0;
    repeat (3) @(negedge opclk);
    check("rst_done", oDONE, 1'b0);
    check("rst_valid", oINSTR_VALID, 1'b0);
    inRST = 1'b1;
    @(negedge opclk);
    iWPARAM = 7'd4; iLPARAM = 8'd0; iCOMMAND = 16'd0;
    #1 check("rst_status", oDATA, 32'd0);
    iWPARAM = IDLE_OP;

    // global memory, including an aliased upper-address write
    host(7'd3, 8'd0, 16'h0000, 32'h0000DEAD);
    host(7'd3, 8'd0, 16'h0005, 32'h00001234);
    host(7'd3, 8'd0, 16'hFC07, 32'hCAFEF00D);

    // 11 words, 2 passes, stride 4, fixed ready with a 5-cycle stall after word 5
    for (int i = 0; i < 11; i++) push_word($urandom);
    set_cycles(2, 4);
    stall_at = 5;
    start_run();
    wait_done("run1");
    read_status(st);
    check("run1_status", st, exp_status(1, 1, m_ofst(), m_pmem.size(), 0, m_nc, m_nc));
    check("run1_ofst_field", 32'(st[29:24]), 32'd8);
    check("run1_cyc_field", 32'(st[3:0]), 32'd2);

    iGMEM_ADDR = 17'd5;       #1 check("gmem_5", oGMEM_RDATA, 32'h00001234);
    iGMEM_ADDR = 17'h10005;   #1 check("gmem_5_alias", oGMEM_RDATA, 32'h00001234);
    iGMEM_ADDR = 17'd7;       #1 check("gmem_7", oGMEM_RDATA, 32'hCAFEF00D);
    iGMEM_ADDR = 17'd0;
`ifdef GPPCU_QUEUE_OFST_OVERLAY_EN
    #1 check("gmem_0_overlay", oGMEM_RDATA, m_ofst());
`else
    #1 check("gmem_0", oGMEM_RDATA, 32'h0000DEAD);
`endif

    // push while running is ignored
    push_word($urandom);
    read_status(st);
    check("push_running", st, exp_status(1, 1, m_ofst(), m_pmem.size(), 0, m_nc, m_nc));
    stall_at = 0;

    // stop mid-run, then replay from word 0 with random ready
    stop_run();
    set_cycles(3, $urandom_range(0, 65535));
    rdy_random = 1'b1;
    start_run();
    repeat (15) @(posedge aclk);
    host(7'd4, 8'd0, 16'd0, 32'd0);
    m_running = 1'b0;
    repeat (4) @(negedge aclk);
    check("stop_valid", oINSTR_VALID, 1'b0);
    check("stop_done", oDONE, 1'b0);
    read_status(st);
    check("stop_status", st, exp_status(0, 0, 0, m_pmem.size(), 0, m_nc, 0));
    start_run();
    wait_done("replay");
    read_status(st);
    check("replay_status", st, exp_status(1, 1, m_ofst(), m_pmem.size(), 0, m_nc, m_nc));

    // zero passes: done without any instruction
    stop_run();
    set_cycles(0, 9);
    start_run();
    wait_done("nc0");
    check("nc0_handshakes", hs, 0);
    read_status(st);
    check("nc0_status", st, exp_status(1, 1, 0, m_pmem.size(), 0, 0, 0));

    // clear program
    host(7'd4, 8'd3, 16'd0, 32'd0);
    m_running = 1'b0;
    m_pmem.delete();
    repeat (5) @(negedge aclk);
    read_status(st);
    check("clear_status", st, exp_status(0, 0, 0, 0, 0, m_nc, 0));

    // random program and pass count
    begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) push_word($urandom);
    end
    set_cycles($urandom_range(1, 4), $urandom_range(0, 65535));
    start_run();
    wait_done("rand");
    read_status(st);
    check("rand_status", st, exp_status(1, 1, m_ofst(), m_pmem.size(), 0, m_nc, m_nc));
    stop_run();

    // fill to the 4095-word limit; one more push is dropped
    host(7'd4, 8'd3, 16'd0, 32'd0);
    m_pmem.delete();
    for (int i = 0; i < 4095; i++) push_word(32'(i));
    read_status(st);
    check("full_pend", 32'(st[23:16]), 32'(m_pmem.size() & 255));
    push_word(32'hFFFF_FFFF);
    read_status(st);
    check("full_hold", 32'(st[23:16]), 32'h000000FF);
    host(7'd4, 8'd3, 16'd0, 32'd0);
    m_pmem.delete();
    read_status(st);
    check("full_clear", 32'(st[23:16]), 32'd0);

    // local-memory proxy
    rd = $urandom;
    @(negedge opclk);
    iWPARAM = 7'd2; iLPARAM = 8'd1; iCOMMAND = 16'd3; iDATA = rd;
    #1;
    check("lmem_wr", oLMEM_WR, 1'b1);
    check("lmem_wr_rd", oLMEM_RD, 1'b0);
    check("lmem_sel", oLMEM_THREAD_SEL, 8'd1);
    check("lmem_addr", oLMEM_ADDR, 16'd3);
    check("lmem_wdata", oLMEM_WDATA, rd);
    iWPARAM = 7'd1; iLMEM_RDATA = $urandom;
    #1;
    check("lmem_rd", oLMEM_RD, 1'b1);
    check("lmem_rdata", oDATA, iLMEM_RDATA);
    iWPARAM = IDLE_OP;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
